// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way branch target buffer.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int tag_width(input int pc_w, input int idx_w);
    return pc_w - idx_w;
  endfunction

  function automatic ctr_t SAT_INC(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t SAT_DEC(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/counter registers, target RAM, a registered lookup
// port, a combinational update-read port and a write port sharing its index.
module btb_way
  import btb_pkg::*;
#(
  parameter int PC_W  = 13,
  parameter int IDX_W = 9,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             i_lk_zero,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_lk_hit,
  output ctr_t             o_lk_ctr,
  output logic [PC_W-1:0]  o_lk_tgt,
  input  logic [IDX_W-1:0] i_up_idx,
  input  logic [TAG_W-1:0] i_up_tag,
  output logic             o_up_valid,
  output logic             o_up_hit,
  output ctr_t             o_up_ctr,
  input  logic             i_wr_en,
  input  logic             i_wr_tgt_en,
  input  ctr_t             i_wr_ctr,
  input  logic [PC_W-1:0]  i_wr_tgt,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_clr_idx
);

  localparam int SETS = 1 << IDX_W;

  logic             r_valid   [SETS];
  logic [TAG_W-1:0] r_tag     [SETS];
  ctr_t             r_ctr     [SETS];
  logic [PC_W-1:0]  r_tgt_mem [SETS];

  assign o_up_valid = r_valid[i_up_idx];
  assign o_up_hit   = r_valid[i_up_idx] && (r_tag[i_up_idx] == i_up_tag);
  assign o_up_ctr   = r_ctr[i_up_idx];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid[i_clr_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[i_up_idx] <= 1'b1;
    end
    if (i_wr_en) begin
      r_tag[i_up_idx] <= i_up_tag;
      r_ctr[i_up_idx] <= i_wr_ctr;
    end
  end

  // Target storage kept in its own block so it maps onto a RAM.
  always_ff @(posedge clk) begin
    if (i_wr_tgt_en) r_tgt_mem[i_up_idx] <= i_wr_tgt;
    o_lk_tgt <= r_tgt_mem[i_lk_idx];
  end

  always_ff @(posedge clk) begin
    o_lk_hit <= !i_lk_zero && r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
    o_lk_ctr <= r_ctr[i_lk_idx];
  end

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB with per-set LRU, a power-on invalidation sweep
// and the D/E redirect mux feeding the instruction ROM.
module btb_2way
  import btb_pkg::*;
#(
  parameter int   PC_W     = 13,
  parameter int   IDX_W    = 9,
  parameter ctr_t CTR_INIT = 2'b10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] pcF,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            busy,
  input  logic [PC_W-1:0] pcD,
  input  logic [PC_W-1:0] nextpcD,
  input  logic            fail_predictD,
  input  logic [PC_W-1:0] pcE,
  input  logic [PC_W-1:0] nextpcE,
  input  logic            takenE,
  input  logic            resolveE,
  input  logic            fail_predictE,
  output logic [PC_W-1:0] nextpc,
  output logic            fail_predict
);

  localparam int TAG_W = tag_width(PC_W, IDX_W);
  localparam int SETS  = 1 << IDX_W;

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_lru [SETS];

  logic             w_lk_hit0, w_lk_hit1, w_up_valid0, w_up_valid1, w_up_hit0, w_up_hit1;
  ctr_t             w_lk_ctr0, w_lk_ctr1, w_up_ctr0, w_up_ctr1, w_ctr_new, w_wr_ctr;
  logic [PC_W-1:0]  w_lk_tgt0, w_lk_tgt1, w_up_pc, w_up_tgt;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_e, w_up_req, w_up_taken, w_hit0, w_hit1, w_hit, w_victim;
  logic             w_wr0, w_wr1, w_clr, w_lk_zero;

  assign nextpc       = fail_predictE ? nextpcE : nextpcD;
  assign fail_predict = fail_predictD | fail_predictE;

  assign busy      = (r_state == CLEAR);
  assign w_clr     = (r_state == CLEAR) && !RST;
  assign w_lk_zero = RST || (r_state == CLEAR);

  // E wins; a D redirect alongside an E update is flushed and dropped.
  assign w_up_e     = resolveE | fail_predictE;
  assign w_up_req   = (r_state == READY) && !RST && (w_up_e || fail_predictD);
  assign w_up_pc    = w_up_e ? pcE : pcD;
  assign w_up_tgt   = w_up_e ? nextpcE : nextpcD;
  assign w_up_taken = w_up_e ? takenE : 1'b1;
  assign w_up_idx   = w_up_pc[IDX_W-1:0];
  assign w_up_tag   = w_up_pc[PC_W-1:IDX_W];

  assign w_hit0    = w_up_hit0;
  assign w_hit1    = w_up_hit1 && !w_up_hit0;
  assign w_hit     = w_hit0 || w_hit1;
  assign w_victim  = !w_up_valid0 ? 1'b0 : (!w_up_valid1 ? 1'b1 : r_lru[w_up_idx]);
  assign w_ctr_new = w_up_taken ? SAT_INC(w_hit0 ? w_up_ctr0 : w_up_ctr1)
                                : SAT_DEC(w_hit0 ? w_up_ctr0 : w_up_ctr1);
  assign w_wr_ctr  = w_hit ? w_ctr_new : CTR_INIT;
  assign w_wr0     = w_up_req && (w_hit0 || (!w_hit && w_up_taken && !w_victim));
  assign w_wr1     = w_up_req && (w_hit1 || (!w_hit && w_up_taken &&  w_victim));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == '1) r_state <= READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_lru[r_clr_idx] <= 1'b0;
    end else if (w_up_req && (w_hit || w_up_taken)) begin
      r_lru[w_up_idx] <= w_hit ? !w_hit1 : !w_victim;
    end
  end

  btb_way #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(CLK), .i_lk_zero(w_lk_zero),
    .i_lk_idx(pcF[IDX_W-1:0]), .i_lk_tag(pcF[PC_W-1:IDX_W]),
    .o_lk_hit(w_lk_hit0), .o_lk_ctr(w_lk_ctr0), .o_lk_tgt(w_lk_tgt0),
    .i_up_idx(w_up_idx), .i_up_tag(w_up_tag),
    .o_up_valid(w_up_valid0), .o_up_hit(w_up_hit0), .o_up_ctr(w_up_ctr0),
    .i_wr_en(w_wr0), .i_wr_tgt_en(w_wr0 && w_up_taken),
    .i_wr_ctr(w_wr_ctr), .i_wr_tgt(w_up_tgt),
    .i_clr(w_clr), .i_clr_idx(r_clr_idx)
  );

  btb_way #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(CLK), .i_lk_zero(w_lk_zero),
    .i_lk_idx(pcF[IDX_W-1:0]), .i_lk_tag(pcF[PC_W-1:IDX_W]),
    .o_lk_hit(w_lk_hit1), .o_lk_ctr(w_lk_ctr1), .o_lk_tgt(w_lk_tgt1),
    .i_up_idx(w_up_idx), .i_up_tag(w_up_tag),
    .o_up_valid(w_up_valid1), .o_up_hit(w_up_hit1), .o_up_ctr(w_up_ctr1),
    .i_wr_en(w_wr1), .i_wr_tgt_en(w_wr1 && w_up_taken),
    .i_wr_ctr(w_wr_ctr), .i_wr_tgt(w_up_tgt),
    .i_clr(w_clr), .i_clr_idx(r_clr_idx)
  );

  // Way 0 wins on a (theoretically impossible) double hit.
  assign pred_hit    = w_lk_hit0 | w_lk_hit1;
  assign pred_taken  = w_lk_hit0 ? w_lk_ctr0[1] : (w_lk_hit1 & w_lk_ctr1[1]);
  assign pred_target = w_lk_hit0 ? w_lk_tgt0 : (w_lk_hit1 ? w_lk_tgt1 : '0);

endmodule
